// File: rtl/ternary_pkg.sv
// Shared types for the ternary select packer: select codes and packer states.
package ternary_pkg;

   typedef logic [1:0] sel_code_t;

   localparam sel_code_t SEL_ZERO = 2'b00;
   localparam sel_code_t SEL_POS  = 2'b01;
   localparam sel_code_t SEL_NEG  = 2'b10;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/ternary_sel_encode.sv
// Combinational ternary value -> 2-bit select code classifier.
// Build option SEL_PACK_SAT_EN: when defined, any value is mapped by sign
// (positive -> POS, negative -> NEG, zero -> ZERO) and nothing is illegal.
// When undefined, only 0, +1 and -1 are legal; anything else maps to ZERO
// and raises o_illegal.
module ternary_sel_encode
   import ternary_pkg::*;
#(
   parameter int DATA_W = 7
) (
   input  logic [DATA_W-1:0] i_value,
   output sel_code_t         o_code,
   output logic              o_illegal
);

   // classify the incoming value
   always_comb begin
      o_code    = SEL_ZERO;
      o_illegal = 1'b0;
`ifdef SEL_PACK_SAT_EN
      if (i_value[DATA_W-1])
         o_code = SEL_NEG;
      else if (|i_value)
         o_code = SEL_POS;
`else
      if (i_value == '0)
         o_code = SEL_ZERO;
      else if (i_value == DATA_W'(1))
         o_code = SEL_POS;
      else if (&i_value)
         o_code = SEL_NEG;
      else
         o_illegal = 1'b1;
`endif
   end

endmodule

// File: rtl/ternary_sel_packer.sv
// Packs a stream of ternary values into words of LANES 2-bit select codes.
// Lane 0 receives the first value of a word; in_last closes a word early.
// The packed word is registered (one cycle after the closing value) and held
// until the consumer takes it; a new value may be taken in the same cycle the
// held word drains, so back-to-back words need no bubble.
// Build option SEL_PACK_SAT_EN selects the saturating encode (see encoder).
module ternary_sel_packer
   import ternary_pkg::*;
#(
   parameter int DATA_W = 7,
   parameter int LANES  = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W-1:0]          in_data,
   input  logic                       in_last,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [2*LANES-1:0]         out_word,
   output logic [$clog2(LANES+1)-1:0] out_count,
   output logic                       err
);

   localparam int IDX_W = $clog2(LANES);
   localparam int CNT_W = $clog2(LANES+1);

   state_t             r_state;
   logic [IDX_W-1:0]   r_idx;
   logic [2*LANES-1:0] r_stage;
   logic               r_out_valid;
   logic [2*LANES-1:0] r_out_word;
   logic [CNT_W-1:0]   r_out_count;
   logic               r_err;

   sel_code_t          w_code;
   logic               w_illegal;
   logic               w_accept;
   logic               w_close;
   logic               w_drain;
   logic [2*LANES-1:0] w_stage_nxt;

   ternary_sel_encode #(
      .DATA_W (DATA_W)
   ) u_encode (
      .i_value   (in_data),
      .o_code    (w_code),
      .o_illegal (w_illegal)
   );

   assign in_ready  = !r_out_valid || out_ready;
   assign out_valid = r_out_valid;
   assign out_word  = r_out_word;
   assign out_count = r_out_count;
   assign err       = r_err;

   assign w_accept = in_valid && in_ready;
   assign w_close  = w_accept && (in_last || (r_idx == IDX_W'(LANES-1)));
   assign w_drain  = (r_state == HOLD) && out_ready;

   // staging word with the current value dropped into its lane
   always_comb begin
      w_stage_nxt = r_stage;
      w_stage_nxt[2*r_idx +: 2] = w_code;
   end

   // lane accumulation, word presentation and drain
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= FILL;
         r_idx       <= '0;
         r_stage     <= '0;
         r_out_valid <= 1'b0;
         r_out_word  <= '0;
         r_out_count <= '0;
         r_err       <= 1'b0;
      end else begin
         if (w_drain) begin
            r_out_valid <= 1'b0;
            r_state     <= FILL;
         end
         if (w_accept) begin
            if (w_illegal)
               r_err <= 1'b1;
            if (w_close) begin
               // staging is wiped so an early-closed word never leaks lanes
               r_out_word  <= w_stage_nxt;
               r_out_count <= CNT_W'(r_idx) + CNT_W'(1);
               r_out_valid <= 1'b1;
               r_state     <= HOLD;
               r_idx       <= '0;
               r_stage     <= '0;
            end else begin
               r_stage <= w_stage_nxt;
               r_idx   <= r_idx + IDX_W'(1);
            end
         end
      end
   end

endmodule
